rr_arb_mux_8x1: RTL and testbench
=================================

Name: rr_arb_mux_8x1

Overview:
- Round-robin arbiter and sequencer that shares one mux_8x1_nbit datapath among 8 requesters.
- Picks one requesting source and drives the mux select.
- Registers the selected word and presents it downstream with a valid/ready handshake.
- Sits between the 8 producer lanes and a single consumer.

Parameters:
- N, 3, data width of each lane and of the output word.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- req  input  8  request per lane; bit i for lane wi
- w0..w7  input  N each  lane data; must be stable while its req is high
- f_ready  input  1  consumer accepts f when high with f_valid
- s  output  3  current mux select, equal to the granted lane index
- gnt  output  8  one-hot grant, 0 when idle
- f  output  N  registered output word
- f_valid  output  1  f holds a valid word
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, ptr=0, s=0, gnt=0, f=0, f_valid=0, busy=0. Reset mid-transfer discards the held word with no partial handshake.
- ptr is a 3-bit priority pointer.
- Pick rule:
  - Search lanes in order ptr, ptr+1, … wrapping 7→0.
  - The first lane with req high wins.
- FSM states: IDLE, HOLD.
- IDLE:
  - If req≠0 at edge k, capture winner index into s and one-hot into gnt, load f with the mux output for the winner, set f_valid=1, go to HOLD.
  - Latency: req sampled at edge k → f_valid high after edge k.
- HOLD:
  - f, s and gnt stay stable while f_ready=0.
  - Deasserting req of the granted lane does not revoke the grant; the word is already captured.
- Transfer: f_valid=1 and f_ready=1 at an edge.
  - ptr ← s+1 mod 8 (7 wraps to 0).
  - If req≠0 at that same edge, pick again using the updated ptr and reload f/s/gnt in the same edge; f_valid stays 1 and the state stays HOLD. This gives one word per cycle when f_ready is held high.
  - Otherwise go to IDLE with f_valid=0, gnt=0; s keeps its last value.
- Fairness: a continuously requesting lane is served within 8 transfers.
- Simultaneous req on all lanes with ptr=0: lane 0 first, then lanes 1..7 in order.
- f_ready high while f_valid=0 is ignored.
- busy=1 exactly when state=HOLD.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - If lock=1 at a transfer edge and the granted lane's req is still 1, ptr is not advanced and the same lane is regranted, so bursts are atomic.
  - lock is ignored in IDLE.
- Not defined: no lock port; behaviour exactly as above.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=8, SEL_W=3.
  - State enum {IDLE, HOLD}.
  - Function onehot_from_idx.
- Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0]. Implemented as rotate, find-first-set, un-rotate.
- Datapath reuses the existing mux_8x1_nbit #(.N(N)), with its select driven by the pick result during capture.

Test Plan:
- Reset: rst_n=0 for 2 edges with req=8'hFF → gnt=0, f_valid=0, f=0, s=0 throughout; one cycle after rst_n=1, gnt=8'h01 and f=w0.
- Single request: req=8'h20, w5=3'b101, f_ready=1 → next edge s=5, gnt=8'h20, f=5, f_valid=1; after req drops, f_valid=0 one edge after the transfer.
- Full contention: req=8'hFF, f_ready=1, distinct wi=i → s sequence 0,1,…,7,0 on consecutive edges, one word per cycle.
- Backpressure: req=8'h0C, f_ready=0 for 4 cycles → s=2, f=w2 held stable; f_ready=1 → lane 2 transfers, then s=3.
- Wrap and skip: ptr=6 after serving lane 5, req=8'h03 → lane 0 granted, then lane 1.
- With RR_ARB_LOCK_EN: lock=1, req=8'h12, lane 1 granted → lane 1 is regranted on every transfer until lock=0, then lane 4 is granted.

Source files
------------

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// mux_arb_pkg : shared constants, FSM state type and helpers for rr_arb_mux_8x1
// Rev 1.0
// ============================================================================
package mux_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot_from_idx(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_8x1_nbit.sv
`default_nettype none
// ============================================================================
// mux_8x1_nbit : plain 8-to-1 multiplexer of N-bit lanes
// Rev 1.0
// ============================================================================
module mux_8x1_nbit #(
  parameter int N = 3
) (
  input  logic [N-1:0] w0,
  input  logic [N-1:0] w1,
  input  logic [N-1:0] w2,
  input  logic [N-1:0] w3,
  input  logic [N-1:0] w4,
  input  logic [N-1:0] w5,
  input  logic [N-1:0] w6,
  input  logic [N-1:0] w7,
  input  logic [2:0]   s,
  output logic [N-1:0] f
);

  always_comb begin
    f = w0;
    case (s)
      3'd0: f = w0;
      3'd1: f = w1;
      3'd2: f = w2;
      3'd3: f = w3;
      3'd4: f = w4;
      3'd5: f = w5;
      3'd6: f = w6;
      3'd7: f = w7;
      default: f = w0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// rr_pick8 : first requester at or after ptr, wrapping 7->0 (rotate/FFS/unrotate)
// Rev 1.0
// ============================================================================
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Rotating right by ptr puts lane ptr at bit 0, so the lowest set bit wins.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    found = 1'b0;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        found = 1'b1;
        w_off = SEL_W'(k);
      end
    end
  end

  assign idx = ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux_8x1.sv
`default_nettype none
// ============================================================================
// rr_arb_mux_8x1 : round-robin arbiter sharing one 8:1 mux, valid/ready output
// Optional: define RR_ARB_LOCK_EN to add a lock input for atomic bursts. Rev 1.0
// ============================================================================
module rr_arb_mux_8x1
  import mux_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [N-1:0]       w0,
  input  logic [N-1:0]       w1,
  input  logic [N-1:0]       w2,
  input  logic [N-1:0]       w3,
  input  logic [N-1:0]       w4,
  input  logic [N-1:0]       w5,
  input  logic [N-1:0]       w6,
  input  logic [N-1:0]       w7,
  input  logic               f_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [SEL_W-1:0]   s,
  output logic [NUM_REQ-1:0] gnt,
  output logic [N-1:0]       f,
  output logic               f_valid,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [N-1:0]       f_q, f_d;

  logic               w_xfer;
  logic               w_keep;
  logic [SEL_W-1:0]   w_xfer_ptr;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;
  logic [SEL_W-1:0]   w_sel;
  logic [N-1:0]       w_mux_f;

  assign w_xfer = (state_q == HOLD) && f_ready;

`ifdef RR_ARB_LOCK_EN
  assign w_keep = lock && req[s_q];
`else
  assign w_keep = 1'b0;
`endif

  // On a transfer the pick must already see the advanced pointer.
  assign w_xfer_ptr = w_keep ? s_q : s_q + 1'b1;
  assign w_pick_ptr = w_xfer ? w_xfer_ptr : ptr_q;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_sel = w_found ? w_idx : s_q;

  mux_8x1_nbit #(.N(N)) u_mux (
    .w0 (w0),
    .w1 (w1),
    .w2 (w2),
    .w3 (w3),
    .w4 (w4),
    .w5 (w5),
    .w6 (w6),
    .w7 (w7),
    .s  (w_sel),
    .f  (w_mux_f)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    f_d     = f_q;
    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d = HOLD;
          s_d     = w_idx;
          gnt_d   = onehot_from_idx(w_idx);
          f_d     = w_mux_f;
        end
      end
      HOLD: begin
        if (w_xfer) begin
          ptr_d = w_xfer_ptr;
          if (w_found) begin
            s_d   = w_idx;
            gnt_d = onehot_from_idx(w_idx);
            f_d   = w_mux_f;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      s_q     <= '0;
      gnt_q   <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      f_q     <= f_d;
    end
  end

  assign s       = s_q;
  assign gnt     = gnt_q;
  assign f       = f_q;
  assign f_valid = (state_q == HOLD);
  assign busy    = (state_q == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux_8x1.sv
`default_nettype none
// ============================================================================
// tb_rr_arb_mux_8x1 : directed plus random stimulus against a behavioural model
// Rev 1.0
// ============================================================================
module tb_rr_arb_mux_8x1;

  localparam int N = 3;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [N-1:0] w [8];
  logic         f_ready;
  logic         lock;
  logic [2:0]   s;
  logic [7:0]   gnt;
  logic [N-1:0] f;
  logic         f_valid;
  logic         busy;

  int n_checks;
  int n_fail;

  // Reference state: pointer, whether a word is held, granted lane and word.
  int           m_ptr;
  bit           m_hold;
  int           m_s;
  logic [N-1:0] m_f;

  rr_arb_mux_8x1 #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .w0      (w[0]),
    .w1      (w[1]),
    .w2      (w[2]),
    .w3      (w[3]),
    .w4      (w[4]),
    .w5      (w[5]),
    .w6      (w[6]),
    .w7      (w[7]),
    .f_ready (f_ready),
`ifdef RR_ARB_LOCK_EN
    .lock    (lock),
`endif
    .s       (s),
    .gnt     (gnt),
    .f       (f),
    .f_valid (f_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int  i;
    int  np;
    bit  locked;
    if (!rst_n) begin
      m_ptr = 0; m_hold = 0; m_s = 0; m_f = '0;
    end else if (!m_hold) begin
      i = pick(req, m_ptr);
      if (i >= 0) begin m_s = i; m_f = w[i]; m_hold = 1; end
    end else if (f_ready) begin
      locked = 0;
`ifdef RR_ARB_LOCK_EN
      locked = lock && req[m_s];
`endif
      np    = locked ? m_s : (m_s + 1) % 8;
      m_ptr = np;
      i     = pick(req, np);
      if (i >= 0) begin m_s = i; m_f = w[i]; end
      else m_hold = 0;
    end
  endtask

  task automatic compare_all();
    check("s", 32'(s), 32'(m_s));
    check("gnt", 32'(gnt), m_hold ? (32'd1 << m_s) : 32'd0);
    check("f", 32'(f), 32'(m_f));
    check("f_valid", 32'(f_valid), 32'(m_hold));
    check("busy", 32'(busy), 32'(m_hold));
  endtask

  // One clock: inputs already applied at the falling edge, model follows the rising edge.
  task automatic step(input logic [7:0] r, input logic rdy, input logic lk);
    req = r; f_ready = rdy; lock = lk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_ptr = 0; m_hold = 0; m_s = 0; m_f = '0;
    rst_n = 1'b0; req = '0; f_ready = 1'b0; lock = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = N'(i);
    @(negedge clk);

    // Reset held for two edges with every lane requesting.
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_f", 32'(f), 32'h0);
    rst_n = 1'b1;
    step(8'hFF, 1'b0, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'h01);
    check("post_rst_f", 32'(f), 32'(w[0]));

    // Single request on lane 5.
    rst_n = 1'b0; step(8'h00, 1'b0, 1'b0); rst_n = 1'b1;
    w[5] = 3'b101;
    step(8'h20, 1'b1, 1'b0);
    check("single_s", 32'(s), 32'd5);
    check("single_f", 32'(f), 32'd5);
    step(8'h00, 1'b1, 1'b0);
    check("single_done", 32'(f_valid), 32'd0);

    // Full contention: one word per cycle in lane order.
    rst_n = 1'b0; step(8'h00, 1'b0, 1'b0); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) w[i] = N'(i);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      check("contention_s", 32'(s), 32'(i % 8));
      check("contention_f", 32'(f), 32'(i % 8));
    end

    // Backpressure holds lane 2, then transfer moves on to lane 3.
    rst_n = 1'b0; step(8'h00, 1'b0, 1'b0); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(8'h0C, 1'b0, 1'b0);
      check("bp_s", 32'(s), 32'd2);
      check("bp_f", 32'(f), 32'(w[2]));
    end
    step(8'h0C, 1'b1, 1'b0);
    check("bp_next", 32'(s), 32'd3);

    // Pointer at 6 after lane 5, then only lanes 0/1 request.
    rst_n = 1'b0; step(8'h00, 1'b0, 1'b0); rst_n = 1'b1;
    step(8'h20, 1'b1, 1'b0);
    step(8'h03, 1'b1, 1'b0);
    check("wrap_lane0", 32'(s), 32'd0);
    step(8'h03, 1'b1, 1'b0);
    check("wrap_lane1", 32'(s), 32'd1);

`ifdef RR_ARB_LOCK_EN
    rst_n = 1'b0; step(8'h00, 1'b0, 1'b0); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'h12, 1'b1, 1'b1);
      check("lock_s", 32'(s), 32'd1);
    end
    step(8'h12, 1'b1, 1'b0);
    check("unlock_s", 32'(s), 32'd4);
`endif

    // Random traffic with occasional reset mid-transfer.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) w[i] = N'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step(8'($urandom & $urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
